// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - memory op and FSM state encodings plus op classification helpers
package mem_access_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic half_op;
    logic word_op;
    half_op = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
    word_op = (op == MEM_LW) || (op == MEM_SW);
    return (half_op && lo[0]) || (word_op && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// rtl/mem_access_lane_align.sv - mem_lane_align: store lane replication/strobes and load extract/extend
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rdata[7:0];
    case (addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    // addr_lo[0] is ignored for halves so a non-trapping build proceeds aligned
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata = store_data;
    wstrb = 4'b0000;
    case (op)
      MEM_SB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MEM_SH: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      MEM_SW:  wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    case (op)
      MEM_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: load_data = {24'h0, ld_byte};
      MEM_LH:  load_data = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: load_data = {16'h0, ld_half};
      MEM_LW:  load_data = rdata;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store stage FSM; MEM_MISALIGN_TRAP_EN enables misaligned-access trapping
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] alu_c,
  input  logic [31:0]       rf_rd2,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_data,
  output logic              misalign
);

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rd2_q;
  logic [31:0]       wb_data_q;
  logic [31:0]       load_data;
  logic              accept;
  logic              mis_in;

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis_in = is_misaligned(mem_op, alu_c[1:0]);

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= mis_in;
    end
  end

  assign misalign = mis_q;
`else
  assign mis_in   = 1'b0;
  assign misalign = 1'b0;
`endif

  assign accept = ex_valid && ex_ready;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ex_ready = 1'b0;
    bus_req  = 1'b0;
    wb_valid = 1'b0;
    case (state_q)
      IDLE: ex_ready = 1'b1;
      REQ: begin
        bus_req = 1'b1;
        if (bus_ack) state_d = DONE;
      end
      DONE: begin
        wb_valid = 1'b1;
        ex_ready = wb_ready;
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ex_valid && ex_ready) begin
      state_d = ((mem_op == MEM_NONE) || mis_in) ? DONE : REQ;
    end
  end

  // Bus fields derive only from the latched op, so they stay frozen for the whole request
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      op_q      <= MEM_NONE;
      addr_q    <= '0;
      rd2_q     <= 32'h0;
      wb_data_q <= 32'h0;
    end else if (accept) begin
      op_q      <= mem_op;
      addr_q    <= alu_c;
      rd2_q     <= rf_rd2;
      wb_data_q <= ((mem_op == MEM_NONE) || mis_in) ? 32'(alu_c) : 32'h0;
    end else if ((state_q == REQ) && bus_ack && is_load(op_q)) begin
      wb_data_q <= load_data;
    end
  end

  mem_lane_align u_lane (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (rd2_q),
    .rdata      (bus_rdata),
    .wdata      (bus_wdata),
    .wstrb      (bus_wstrb),
    .load_data  (load_data)
  );

  assign bus_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_we   = is_store(op_q);
  assign wb_data  = wb_data_q;

endmodule
